// File: rtl/mem_lsu.sv
// Load/store initiator for a single-port word memory: byte/half/word requests in,
// lane-enable writes or aligned reads out, extended data back on a response handshake.
module mem_lsu #(
  parameter int unsigned WORDS  = 256,
  parameter int unsigned ADDR_W = 22
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [3:0]        mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_e;

  state_e            state_q, state_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic [3:0]        mem_wen_q, mem_wen_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [1:0]        lane_q, lane_d;
  logic [1:0]        size_q, size_d;
  logic              sgn_q, sgn_d;
  logic              we_q, we_d;

  logic              accept_c;
  logic              err_c;
  logic [3:0]        st_wen_c;
  logic [31:0]       st_wdata_c;
  logic [7:0]        byte_c;
  logic [15:0]       half_c;
  logic [31:0]       load_c;

  // Request decode: error classification and store lane steering
  always_comb begin
    accept_c = (state_q == IDLE) && req_valid && req_ready_q;
    err_c    = (req_size == 2'd3)
            || ((req_size == 2'd1) && req_addr[0])
            || ((req_size == 2'd2) && (req_addr[1:0] != 2'd0))
            || (req_addr[31:2] >= 30'(WORDS));
    st_wen_c   = 4'b1111;
    st_wdata_c = req_wdata;
    case (req_size)
      2'd0: begin
        st_wen_c   = 4'b0001 << req_addr[1:0];
        st_wdata_c = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        st_wen_c   = req_addr[1] ? 4'b1100 : 4'b0011;
        st_wdata_c = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Load lane extraction and extension from the latched request
  always_comb begin
    case (lane_q)
      2'd0:    byte_c = mem_rdata[7:0];
      2'd1:    byte_c = mem_rdata[15:8];
      2'd2:    byte_c = mem_rdata[23:16];
      default: byte_c = mem_rdata[31:24];
    endcase
    half_c = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      2'd0:    load_c = {{24{sgn_q & byte_c[7]}}, byte_c};
      2'd1:    load_c = {{16{sgn_q & half_c[15]}}, half_c};
      default: load_c = mem_rdata;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    mem_wen_d   = 4'b0000;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    lane_d      = lane_q;
    size_d      = size_q;
    sgn_d       = sgn_q;
    we_d        = we_q;
    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (accept_c) begin
          req_ready_d = 1'b0;
          lane_d      = req_addr[1:0];
          size_d      = req_size;
          sgn_d       = req_signed;
          we_d        = req_we;
          if (err_c) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'd0;
          end else begin
            state_d    = ACCESS;
            mem_addr_d = req_addr[ADDR_W+1:2];
            if (req_we) begin
              mem_wen_d   = st_wen_c;
              mem_wdata_d = st_wdata_c;
            end
          end
        end
      end
      ACCESS: begin
        if (we_q) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = 32'd0;
        end else begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = load_c;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = 32'd0;
          req_ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
      mem_wen_q   <= 4'b0000;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
      lane_q      <= 2'd0;
      size_q      <= 2'd0;
      sgn_q       <= 1'b0;
      we_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      mem_wen_q   <= mem_wen_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      lane_q      <= lane_d;
      size_q      <= size_d;
      sgn_q       <= sgn_d;
      we_q        <= we_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mem_wen   = mem_wen_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu with a byte-lane memory model and hand-computed expectations.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [3:0]  mem_wen;
  logic [21:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'd0;

  int checks = 0;
  int failures = 0;
  int wen_cnt = 0;
  int wen_base = 0;
  int lat = 0;
  logic [3:0]  acc_wen;
  logic [21:0] acc_addr;
  logic [31:0] acc_wdata;
  logic [31:0] mem [256];

  mem_lsu dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Single-port memory: byte-lane writes, one-cycle registered read
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (mem_wen[i]) mem[mem_addr[7:0]][8*i +: 8] <= mem_wdata[8*i +: 8];
    mem_rdata <= mem[mem_addr[7:0]];
  end

  always @(negedge clk) if (mem_wen != 4'b0000) wen_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    wen_base = wen_cnt;
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    acc_wen = mem_wen; acc_addr = mem_addr; acc_wdata = mem_wdata;
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic check_rsp(input string tag, input int exp_lat, input logic exp_err,
                           input logic [31:0] exp_data, input int exp_wen);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
    chk({tag, "_rdata"}, rsp_rdata, exp_data);
    chk({tag, "_wen_cycles"}, 32'(wen_cnt - wen_base), 32'(exp_wen));
  endtask

  task automatic complete(input string tag);
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({tag, "_hs_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_hs_err"}, 32'(rsp_err), 32'd0);
    chk({tag, "_hs_rdata"}, rsp_rdata, 32'd0);
    chk({tag, "_hs_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_mem_wen", 32'(mem_wen), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("rel_ready_before_edge", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    chk("rel_ready_after_edge", 32'(req_ready), 32'd1);

    // Word store / word load
    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
    chk("sw_acc_wen", 32'(acc_wen), 32'hF);
    chk("sw_acc_addr", 32'(acc_addr), 32'd4);
    chk("sw_acc_wdata", acc_wdata, 32'hDEADBEEF);
    check_rsp("sw", 2, 1'b0, 32'd0, 1);
    complete("sw");
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'd0);
    chk("lw_acc_wen", 32'(acc_wen), 32'd0);
    chk("lw_acc_addr", 32'(acc_addr), 32'd4);
    check_rsp("lw", 3, 1'b0, 32'hDEADBEEF, 0);
    complete("lw");

    // Byte store then signed/unsigned byte loads and word readback
    issue(1'b1, 2'd0, 1'b0, 32'h13, 32'h000000A5);
    chk("sb_acc_wen", 32'(acc_wen), 32'h8);
    chk("sb_acc_wdata", acc_wdata, 32'hA5A5A5A5);
    check_rsp("sb", 2, 1'b0, 32'd0, 1);
    complete("sb");
    issue(1'b0, 2'd0, 1'b1, 32'h13, 32'd0);
    check_rsp("lb_s", 3, 1'b0, 32'hFFFFFFA5, 0);
    complete("lb_s");
    issue(1'b0, 2'd0, 1'b0, 32'h13, 32'd0);
    check_rsp("lb_u", 3, 1'b0, 32'h000000A5, 0);
    complete("lb_u");
    issue(1'b0, 2'd2, 1'b1, 32'h10, 32'd0);
    check_rsp("lw_lanes", 3, 1'b0, 32'hA5ADBEEF, 0);
    complete("lw_lanes");

    // Half store upper lane, signed/unsigned half loads
    issue(1'b1, 2'd1, 1'b0, 32'h22, 32'h00008001);
    chk("sh_acc_wen", 32'(acc_wen), 32'hC);
    chk("sh_acc_addr", 32'(acc_addr), 32'd8);
    chk("sh_acc_wdata", acc_wdata, 32'h80018001);
    check_rsp("sh", 2, 1'b0, 32'd0, 1);
    complete("sh");
    issue(1'b0, 2'd1, 1'b1, 32'h22, 32'd0);
    check_rsp("lh_s", 3, 1'b0, 32'hFFFF8001, 0);
    complete("lh_s");
    issue(1'b0, 2'd1, 1'b0, 32'h22, 32'd0);
    check_rsp("lh_u", 3, 1'b0, 32'h00008001, 0);
    complete("lh_u");

    // Error cases: no memory access, mem_addr/mem_wdata hold
    issue(1'b0, 2'd1, 1'b0, 32'h21, 32'd0);
    check_rsp("err_lh_mis", 1, 1'b1, 32'd0, 0);
    complete("err_lh_mis");
    issue(1'b1, 2'd2, 1'b0, 32'h22, 32'h11111111);
    check_rsp("err_sw_mis", 1, 1'b1, 32'd0, 0);
    complete("err_sw_mis");
    issue(1'b0, 2'd3, 1'b0, 32'h0, 32'd0);
    check_rsp("err_size3", 1, 1'b1, 32'd0, 0);
    complete("err_size3");
    issue(1'b0, 2'd2, 1'b0, 32'h400, 32'd0);
    check_rsp("err_range", 1, 1'b1, 32'd0, 0);
    complete("err_range");
    chk("err_addr_hold", 32'(mem_addr), 32'd8);
    chk("err_wdata_hold", mem_wdata, 32'h80018001);

    // Last in-range word
    issue(1'b0, 2'd2, 1'b0, 32'h3FC, 32'd0);
    chk("top_acc_addr", 32'(acc_addr), 32'hFF);
    check_rsp("top", 3, 1'b0, 32'd0, 0);
    complete("top");

    // Backpressure with a competing request held on req_valid
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'd0);
    check_rsp("bp", 3, 1'b0, 32'hA5ADBEEF, 0);
    @(negedge clk);
    req_we = 1'b1; req_size = 2'd2; req_addr = 32'h10; req_wdata = 32'h0; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rdata", rsp_rdata, 32'hA5ADBEEF);
      chk("bp_ready", 32'(req_ready), 32'd0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    chk("bp_hs_valid", 32'(rsp_valid), 32'd0);
    chk("bp_hs_ready", 32'(req_ready), 32'd1);
    chk("bp_no_store", 32'(wen_cnt - wen_base), 32'd0);
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'd0);
    check_rsp("bp_next", 3, 1'b0, 32'hA5ADBEEF, 0);
    complete("bp_next");

    // Reset during ACCESS of a word store
    @(negedge clk);
    req_we = 1'b1; req_size = 2'd2; req_addr = 32'h40; req_wdata = 32'h12345678; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("mid_acc_wen", 32'(mem_wen), 32'hF);
    #2 resetn = 1'b0;
    #1;
    chk("mid_rst_wen", 32'(mem_wen), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    chk("mid_rst_addr", 32'(mem_addr), 32'd0);
    chk("mid_rst_wdata", mem_wdata, 32'd0);
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    chk("mid_rel_ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("mid_no_stale", 32'(rsp_valid), 32'd0);
      @(posedge clk); #1;
    end
    issue(1'b0, 2'd2, 1'b0, 32'h40, 32'd0);
    check_rsp("mid_unwritten", 3, 1'b0, 32'd0, 0);
    complete("mid_unwritten");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Load/store initiator that drives the team's single-port word memory (byte-lane write enables, word address, one-cycle registered read).
- Accepts byte, halfword and word requests on a valid/ready interface.
- Converts them to lane-enable writes or aligned reads, then returns sign- or zero-extended data on a response handshake.
- Sits between the core's data port and the memory. Misaligned or out-of-range accesses never reach memory.

Parameters:
WORDS, 256, depth of the attached memory in 32-bit words; word index >= WORDS is out of range
ADDR_W, 22, width of mem_addr (word address)

Ports:
clk  in  1  clock, all state on rising edge
resetn  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request
req_we  in  1  1=store, 0=load
req_size  in  2  0=byte, 1=half, 2=word, 3=illegal
req_signed  in  1  loads only: 1=sign-extend, 0=zero-extend
req_addr  in  32  byte address
req_wdata  in  32  store data, right-justified
rsp_valid  out  1  response present
rsp_ready  in  1  consumer takes response
rsp_rdata  out  32  extended load data; 0 for stores and errors
rsp_err  out  1  misaligned, illegal size or out of range
mem_wen  out  4  byte-lane write enables
mem_addr  out  ADDR_W  word address = req_addr[ADDR_W+1:2]
mem_wdata  out  32  lane-replicated store data
mem_rdata  in  32  memory read data, valid one cycle after address

Behaviour:
- All outputs are registered. While resetn is low: state IDLE, req_ready=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_wen=0, mem_addr=0, mem_wdata=0.
- req_ready rises on the first clock edge after resetn deasserts.
- FSM states: IDLE, ACCESS, CAPTURE, RESP.
- IDLE: req_ready=1. A request is accepted on an edge where req_valid&req_ready. On acceptance, req_ready drops and addr, size, signed and we are latched.
- Error check at acceptance. rsp_err=1 when any of:
  - size==3
  - size==1 and addr[0]=1
  - size==2 and addr[1:0]!=0
  - addr[31:2] >= WORDS
- On error: go directly to RESP with rsp_err=1, rsp_rdata=0. mem_wen stays 0 and no memory access occurs.
- ACCESS (exactly one cycle): mem_addr is driven. For a store, mem_wen and mem_wdata are driven.
  - Byte store: mem_wen = 1<<addr[1:0]; mem_wdata = {4{wdata[7:0]}}.
  - Half store: mem_wen = addr[1] ? 4'b1100 : 4'b0011; mem_wdata = {2{wdata[15:0]}}.
  - Word store: mem_wen = 4'b1111; mem_wdata = wdata.
  - Load: mem_wen = 0.
  - Store next state is RESP. Load next state is CAPTURE.
- mem_wen returns to 0 on the edge leaving ACCESS and is never high for more than one cycle per request.
- CAPTURE (loads, one cycle): mem_rdata is valid and is sampled at the end of this cycle.
  - Byte load: lane addr[1:0] is extracted.
  - Half load: lane addr[1] (bits 31:16 or 15:0) is extracted.
  - The extracted value is sign- or zero-extended per req_signed into rsp_rdata. Word load ignores req_signed.
- RESP: rsp_valid=1. rsp_rdata and rsp_err are held stable until rsp_ready. On the rsp_valid&rsp_ready edge: rsp_valid=0, rsp_err=0, rsp_rdata=0, state IDLE, req_ready=1.
- Latency from the accept edge:
  - Store: rsp_valid after 2 edges.
  - Load: rsp_valid after 3 edges.
  - Error: rsp_valid after 1 edge.
- Throughput is one outstanding request. req_valid is ignored outside IDLE.
- mem_addr holds its last value outside ACCESS/CAPTURE. mem_wdata holds its last value.
- Reset mid-operation: everything returns to reset values immediately and mem_wen goes 0 asynchronously. The pending response is dropped and no retry happens.
- rsp_ready held high in RESP completes in one cycle. rsp_ready outside RESP has no effect.

Test Plan:
- Word store addr 0x10, wdata 0xDEADBEEF, then word load addr 0x10 -> one ACCESS cycle with mem_addr=4, mem_wen=4'hF; load returns 0xDEADBEEF, err=0, rsp_valid 3 edges after accept.
- Byte store 0xA5 to addr 0x13, then signed byte load 0x13 -> mem_wen=4'b1000, mem_wdata=0xA5A5A5A5; load returns 0xFFFFFFA5; unsigned load returns 0x000000A5; other lanes of word 4 unchanged.
- Half store 0x8001 to addr 0x22, signed half load 0x22 -> mem_wen=4'b1100; load returns 0xFFFF8001.
- Errors: half load addr 0x21, word store addr 0x22, size=3, word load addr 0x400 with WORDS=256 -> each gives rsp_err=1, rsp_rdata=0 one edge after accept; mem_wen never nonzero.
- Backpressure: rsp_ready held low 5 cycles after a load completes -> rsp_valid/rsp_rdata stable; req_ready=0 and new req_valid ignored until the handshake; next request accepted the cycle after.
- Reset: assert resetn low during ACCESS of a word store -> mem_wen=0 immediately; after release req_ready=1 one edge later, rsp_valid=0, no stale response.
